// File: rtl/arbiter_client_pkg.sv
// Shared bus definitions for arbiter clients.
// Default widths and the command/response bundles.
package arbiter_client_pkg;

    localparam int BusAddrWidth = 16;
    localparam int BusDataWidth = 16;

    typedef struct packed {
        logic                    write;
        logic [BusAddrWidth-1:0] addr;
        logic [BusDataWidth-1:0] wdata;
    } bus_cmd_t;

    typedef struct packed {
        logic [BusDataWidth-1:0] rdata;
        logic                    err;
    } bus_rsp_t;

endpackage

// File: rtl/arbiter_client.sv
// Requester-side client of the sticky-grant arbiter: requests the bus,
// runs up to MaxBurst transactions per tenure, then releases it.
module arbiter_client
    import arbiter_client_pkg::*;
#(
    parameter int AddrWidth     = BusAddrWidth,
    parameter int DataWidth     = BusDataWidth,
    parameter int MaxBurst      = 4,
    parameter int ReleaseCycles = 1,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [AddrWidth-1:0] cmd_addr,
    input  logic [DataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 bus_req,
    input  logic                 bus_grant,
    output logic                 bus_valid,
    output logic                 bus_write,
    output logic [AddrWidth-1:0] bus_addr,
    output logic [DataWidth-1:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic [DataWidth-1:0] bus_rdata,
    output logic                 grant_lost
);

    localparam int BW = $clog2(MaxBurst + 1);
    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int RW = $clog2(ReleaseCycles + 1);

    localparam logic [BW-1:0] BurstLast = BW'(MaxBurst - 1);
    localparam logic [TW-1:0] TmoLast   = TW'(TimeoutCycles - 1);
    localparam logic [RW-1:0] RelLast   = RW'(ReleaseCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        ACCESS,
        RELEASE
    } state_t;

    state_t state, state_nxt;

    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] rel_cnt;

    logic load;
    logic chain;
    logic ack;
    logic expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        bus_req   = 1'b0;
        bus_valid = 1'b0;
        load      = 1'b0;
        chain     = 1'b0;
        ack       = 1'b0;
        expire    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    load      = 1'b1;
                    state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                bus_req = 1'b1;
                if (bus_grant) state_nxt = ACCESS;
            end
            ACCESS: begin
                bus_req   = 1'b1;
                bus_valid = 1'b1;
                ack       = bus_ack;
                // An ack on the final timeout cycle wins over the abort
                expire    = !bus_ack && (tmo_cnt == TmoLast);
                if (bus_ack) begin
                    cmd_ready = (burst_cnt < BurstLast);
                    if (cmd_ready && cmd_valid) begin
                        load  = 1'b1;
                        chain = 1'b1;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end else if (expire) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt == RelLast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_write  <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            burst_cnt  <= '0;
            tmo_cnt    <= '0;
            rel_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            grant_lost <= 1'b0;
        end else begin
            if (load) begin
                bus_write <= cmd_write;
                bus_addr  <= cmd_addr;
                bus_wdata <= cmd_wdata;
            end
            if (state == IDLE) begin
                burst_cnt <= '0;
            end else if (ack) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
            tmo_cnt <= (state == ACCESS && !chain) ? tmo_cnt + TW'(1) : '0;
            rel_cnt <= (state == RELEASE) ? rel_cnt + RW'(1) : '0;
            rsp_valid <= ack | expire;
            rsp_err   <= expire;
            rsp_rdata <= (ack && !bus_write) ? bus_rdata : '0;
            if (bus_valid && !bus_grant) grant_lost <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arbiter_client.sv
// Directed bench for arbiter_client: cycle vectors, bursts, timeout,
// reset and a two-client sticky-arbiter scenario.
module tb_arbiter_client;
    import arbiter_client_pkg::*;

    localparam int Tmo = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        cv_drv = 1'b0;
    logic        gnt_drv = 1'b0;
    logic        ack_drv = 1'b0;
    logic        arb_mode = 1'b0;
    logic [15:0] rdata_drv = '0;
    bus_cmd_t    cmd = '0;

    logic        cv0, rdy0, rv0, re0, req0, gnt0, bv0, bw0, ack0, gl0;
    logic [15:0] rd0, ba0, bwd0;
    logic        cv1, rdy1, rv1, re1, req1, gnt1, bv1, bw1, ack1, gl1;
    logic [15:0] rd1, ba1, bwd1;
    logic [1:0]  gnt, held;

    assign cv0  = arb_mode ? 1'b1 : cv_drv;
    assign gnt0 = arb_mode ? gnt[0] : gnt_drv;
    assign ack0 = arb_mode ? bv0 : ack_drv;
    assign cv1  = arb_mode;
    assign gnt1 = gnt[1];
    assign ack1 = bv1;

    arbiter_client #(.TimeoutCycles(Tmo)) c0 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv0), .cmd_ready(rdy0), .cmd_write(cmd.write),
        .cmd_addr(cmd.addr), .cmd_wdata(cmd.wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0),
        .bus_req(req0), .bus_grant(gnt0), .bus_valid(bv0),
        .bus_write(bw0), .bus_addr(ba0), .bus_wdata(bwd0),
        .bus_ack(ack0), .bus_rdata(rdata_drv), .grant_lost(gl0)
    );

    arbiter_client #(.TimeoutCycles(Tmo)) c1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_write(1'b1),
        .cmd_addr(16'h0900), .cmd_wdata(16'h0000),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
        .bus_req(req1), .bus_grant(gnt1), .bus_valid(bv1),
        .bus_write(bw1), .bus_addr(ba1), .bus_wdata(bwd1),
        .bus_ack(ack1), .bus_rdata(16'h0000), .grant_lost(gl1)
    );

    // Sticky-grant priority arbiter model: holder keeps grant while requesting
    always_comb begin
        if (held[0] && req0)      gnt = 2'b01;
        else if (held[1] && req1) gnt = 2'b10;
        else if (req0)            gnt = 2'b01;
        else if (req1)            gnt = 2'b10;
        else                      gnt = 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) held <= 2'b00;
        else          held <= gnt;
    end

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cv;
        bus_cmd_t    cmd;
        logic        gnt;
        logic        ack;
        logic [15:0] rd;
        logic [4:0]  e_ctl;
        logic [15:0] e_rdata;
        logic [15:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic cv, input logic w,
                                input logic [15:0] a, input logic [15:0] d,
                                input logic g, input logic k,
                                input logic [15:0] rd, input logic [4:0] ctl,
                                input logic [15:0] erd, input logic [15:0] ea);
        vec_t v;
        v.cv = cv;
        v.cmd.write = w;
        v.cmd.addr = a;
        v.cmd.wdata = d;
        v.gnt = g;
        v.ack = k;
        v.rd = rd;
        v.e_ctl = ctl;
        v.e_rdata = erd;
        v.e_addr = ea;
        return v;
    endfunction

    task automatic tmo_run(input logic ack_last, input string nm);
        int bad;
        bad = 0;
        @(negedge clk);
        cmd.write = 1'b0;
        cmd.addr = 16'h0040;
        cv_drv = 1'b1;
        gnt_drv = 1'b1;
        ack_drv = 1'b0;
        rdata_drv = 16'hDEAD;
        @(negedge clk);
        cv_drv = 1'b0;
        for (int k = 1; k <= Tmo; k++) begin
            @(negedge clk);
            ack_drv = (k == Tmo) && ack_last;
            #1;
            if (!bv0 || rv0) bad++;
        end
        chk({nm, "_window"}, bad, 0);
        @(negedge clk);
        ack_drv = 1'b0;
        #1;
        if (ack_last) chk({nm, "_rsp"}, {rv0, re0, rd0, bv0}, {2'b10, 16'hDEAD, 1'b0});
        else          chk({nm, "_rsp"}, {rv0, re0, rd0, bv0}, {2'b11, 16'h0000, 1'b0});
    endtask

    vec_t tbl[12];
    int   ack_t[6];
    logic [15:0] ack_a[6], ack_d[6];
    int   exp_t[6] = '{2, 3, 4, 5, 9, 10};

    initial begin
        int issued, nack, nrsp, nerr, bad;
        int last, run, runs, badrun, n0, n1;

        // ctl = {cmd_ready, bus_req, bus_valid, rsp_valid, rsp_err}
        tbl[0]  = mk(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 5'b10000, 16'h0000, 16'h0000);
        tbl[1]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b01000, 16'h0000, 16'h0010);
        tbl[2]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b01100, 16'h0000, 16'h0010);
        tbl[3]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b01100, 16'h0000, 16'h0010);
        tbl[4]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'hBEEF, 5'b11100, 16'h0000, 16'h0010);
        tbl[5]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b00010, 16'hBEEF, 16'h0010);
        tbl[6]  = mk(1, 1, 16'h0020, 16'h1234, 0, 0, 16'h0000, 5'b10000, 16'h0000, 16'h0010);
        tbl[7]  = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 5'b01000, 16'h0000, 16'h0020);
        tbl[8]  = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b01000, 16'h0000, 16'h0020);
        tbl[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'hFFFF, 5'b11100, 16'h0000, 16'h0020);
        tbl[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b00010, 16'h0000, 16'h0020);
        tbl[11] = mk(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 5'b10000, 16'h0000, 16'h0020);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_c0", {req0, bv0, rv0, re0, gl0, bw0, ba0}, 0);
        chk("reset_data", {rd0, bwd0}, 0);
        chk("reset_c1", {req1, bv1, rv1, gl1}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cv_drv = tbl[i].cv;
            cmd = tbl[i].cmd;
            gnt_drv = tbl[i].gnt;
            ack_drv = tbl[i].ack;
            rdata_drv = tbl[i].rd;
            #1;
            chk($sformatf("vec%0d", i),
                {rdy0, req0, bv0, rv0, re0, rd0, ba0},
                {tbl[i].e_ctl, tbl[i].e_rdata, tbl[i].e_addr});
        end

        issued = 0;
        nack = 0;
        nrsp = 0;
        nerr = 0;
        for (int i = 0; i < 6; i++) ack_t[i] = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            cmd.write = 1'b1;
            cmd.addr = 16'h0100 + 16'(issued);
            cmd.wdata = 16'hA000 + 16'(issued);
            cv_drv = (issued < 6);
            gnt_drv = 1'b1;
            ack_drv = bv0;
            rdata_drv = 16'h5555;
            #1;
            if (rv0) begin
                nrsp++;
                if (re0 || rd0 != 16'h0000) nerr++;
            end
            if (ack_drv && nack < 6) begin
                ack_t[nack] = t;
                ack_a[nack] = ba0;
                ack_d[nack] = bwd0;
                nack++;
            end
            if (cv_drv && rdy0) issued++;
        end
        cv_drv = 1'b0;
        ack_drv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("burst_ack_cycle%0d", i), ack_t[i], exp_t[i]);
            chk($sformatf("burst_ack_cmd%0d", i), {ack_a[i], ack_d[i]},
                {16'h0100 + 16'(i), 16'hA000 + 16'(i)});
        end
        chk("burst_rsp_count", nrsp, 6);
        chk("burst_rsp_err", nerr, 0);

        @(negedge clk);
        cmd.write = 1'b0;
        cmd.addr = 16'h0030;
        cv_drv = 1'b1;
        gnt_drv = 1'b0;
        #1;
        chk("dg_accept", rdy0, 1);
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            cv_drv = 1'b0;
            #1;
            if (!(req0 && !bv0 && !rdy0)) bad++;
        end
        chk("dg_wait", bad, 0);
        @(negedge clk);
        gnt_drv = 1'b1;
        #1;
        chk("dg_grant_cycle", {req0, bv0}, 2'b10);
        @(negedge clk);
        #1;
        chk("dg_access", {req0, bv0, ba0}, {2'b11, 16'h0030});
        @(negedge clk);
        ack_drv = 1'b1;
        rdata_drv = 16'h1357;
        @(negedge clk);
        ack_drv = 1'b0;
        #1;
        chk("dg_rsp", {rv0, re0, rd0}, {2'b10, 16'h1357});

        tmo_run(1'b0, "tmo");
        tmo_run(1'b1, "tmo_ack_last");

        @(negedge clk);
        cmd.write = 1'b1;
        cmd.addr = 16'h0050;
        cv_drv = 1'b1;
        gnt_drv = 1'b1;
        #1;
        chk("gl_clear", gl0, 0);
        @(negedge clk);
        cv_drv = 1'b0;
        @(negedge clk);
        gnt_drv = 1'b0;
        @(negedge clk);
        gnt_drv = 1'b1;
        #1;
        chk("gl_set", {gl0, bv0}, 2'b11);
        @(negedge clk);
        ack_drv = 1'b1;
        @(negedge clk);
        ack_drv = 1'b0;
        @(negedge clk);
        #1;
        chk("gl_sticky", {gl0, rdy0}, 2'b11);

        @(negedge clk);
        cmd.write = 1'b0;
        cmd.addr = 16'h0060;
        cv_drv = 1'b1;
        @(negedge clk);
        cv_drv = 1'b0;
        @(negedge clk);
        #2;
        ack_drv = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {req0, bv0, rv0, gl0}, 0);
        @(negedge clk);
        ack_drv = 1'b0;
        reset_n = 1'b1;
        #1;
        chk("rst_idle", {rdy0, req0, bv0, rv0}, 4'b1000);
        @(negedge clk);
        cmd.addr = 16'h0070;
        cv_drv = 1'b1;
        rdata_drv = 16'h4242;
        #1;
        chk("rst_no_rsp", rv0, 0);
        @(negedge clk);
        cv_drv = 1'b0;
        @(negedge clk);
        ack_drv = 1'b1;
        #1;
        chk("rst_new_access", {bv0, ba0}, {1'b1, 16'h0070});
        @(negedge clk);
        ack_drv = 1'b0;
        #1;
        chk("rst_new_rsp", {rv0, re0, rd0}, {2'b10, 16'h4242});
        @(negedge clk);

        cmd.write = 1'b0;
        cmd.addr = 16'h0080;
        rdata_drv = 16'h0001;
        arb_mode = 1'b1;
        last = -1;
        run = 0;
        runs = 0;
        badrun = 0;
        n0 = 0;
        n1 = 0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            #1;
            if (rv0) n0++;
            if (rv1) n1++;
            if (ack0 && ack1) badrun++;
            if (ack0 || ack1) begin
                if ((ack0 ? 0 : 1) == last) begin
                    run++;
                end else begin
                    if (last >= 0) begin
                        runs++;
                        if (run != 4) badrun++;
                    end
                    last = ack0 ? 0 : 1;
                    run = 1;
                end
            end
        end
        chk("arb_alternations", runs >= 6, 1);
        chk("arb_tenure_len", badrun, 0);
        chk("arb_c0_served", n0 >= 12, 1);
        chk("arb_c1_served", n1 >= 12, 1);
        chk("arb_fair", (n0 - n1 <= 4) && (n1 - n0 <= 4), 1);
        chk("arb_grant_lost", {gl0, gl1}, 2'b00);
        arb_mode = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
